cgra_input_streamer: RTL and testbench

CGRA_INPUT_STREAMER -- requirements
Module: cgra_input_streamer

---
 rtl/cgra_input_streamer.sv | 142 ++++++++++++++
 tb/tb_cgra_input_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_input_streamer.sv
// Strided read streamer: issues credit-limited reads and feeds the responses to a CGRA input lane.
// Optional stall counter port enabled by defining CGRA_STREAMER_PERF_CNT_EN.
module cgra_input_streamer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  execute_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           size_i,
    input  logic [15:0]           stride_i,
    output logic                  rd_req_valid_o,
    input  logic                  rd_req_ready_i,
    output logic [ADDR_WIDTH-1:0] rd_req_addr_o,
    input  logic                  rd_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] rd_rsp_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  outst_full_o
`ifdef CGRA_STREAMER_PERF_CNT_EN
    ,
    output logic [31:0]           stall_count_o
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             size_q, stride_q, issued_q, delivered_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_W-1:0]        in_flight_q, count_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic                    done_q;

    logic start, running, more, credit_ok, issue, push, pop, last_pop;

    assign running   = (state_q == RUN);
    assign start     = (state_q == IDLE) && execute_i;
    assign more      = issued_q < size_q;
    // Words requested but not yet delivered may never exceed the buffer depth.
    assign credit_ok = ({1'b0, in_flight_q} + {1'b0, count_q}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue     = rd_req_valid_o && rd_req_ready_i;
    // Responses with nothing outstanding are leftovers from before a reset.
    assign push      = rd_rsp_valid_i && running && (in_flight_q != '0);
    assign pop       = data_valid_o && data_ready_i;
    assign last_pop  = pop && (({1'b0, delivered_q} + 17'd1) == {1'b0, size_q});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (execute_i && (size_i != 16'd0)) state_d = RUN;
            RUN:     if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o         = running;
        rd_req_valid_o = running && more && credit_ok;
        outst_full_o   = running && more && !credit_ok;
        rd_req_addr_o  = running ? addr_q : '0;
        data_valid_o   = (count_q != '0);
        data_o         = data_valid_o ? mem_q[rd_ptr_q] : '0;
        done_o         = done_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            size_q      <= '0;
            stride_q    <= '0;
            addr_q      <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            in_flight_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                size_q      <= size_i;
                stride_q    <= stride_i;
                addr_q      <= base_addr_i;
                issued_q    <= '0;
                delivered_q <= '0;
                in_flight_q <= '0;
                count_q     <= '0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                done_q      <= (size_i == 16'd0);
            end else if (running) begin
                if (issue) begin
                    issued_q <= issued_q + 16'd1;
                    addr_q   <= addr_q + ADDR_WIDTH'(stride_q);
                end
                if (issue && !push)      in_flight_q <= in_flight_q + CNT_W'(1);
                else if (!issue && push) in_flight_q <= in_flight_q - CNT_W'(1);
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop) begin
                    rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
                    delivered_q <= delivered_q + 16'd1;
                end
                if (push && !pop)      count_q <= count_q + CNT_W'(1);
                else if (!push && pop) count_q <= count_q - CNT_W'(1);
                if (last_pop) done_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; data_o is masked while the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rd_rsp_data_i;
    end

`ifdef CGRA_STREAMER_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_count_o <= '0;
        end else if (start) begin
            stall_count_o <= '0;
        end else if (running && (outst_full_o || (data_valid_o && !data_ready_i))
                     && (stall_count_o != 32'hFFFF_FFFF)) begin
            stall_count_o <= stall_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cgra_input_streamer.sv
// Randomized bench for cgra_input_streamer with an in-order memory responder and address/data model.
// Stall counter test is included when CGRA_STREAMER_PERF_CNT_EN is defined.
module tb_cgra_input_streamer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b1, execute = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] size = '0, stride = '0;
    logic        rd_req_valid, rd_req_ready = 1'b0;
    logic [31:0] rd_req_addr;
    logic        rd_rsp_valid = 1'b0;
    logic [31:0] rd_rsp_data = '0;
    logic [31:0] data;
    logic        data_valid, data_ready = 1'b0, busy, done, outst_full;
`ifdef CGRA_STREAMER_PERF_CNT_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    cgra_input_streamer #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .execute_i(execute),
        .base_addr_i(base_addr), .size_i(size), .stride_i(stride),
        .rd_req_valid_o(rd_req_valid), .rd_req_ready_i(rd_req_ready), .rd_req_addr_o(rd_req_addr),
        .rd_rsp_valid_i(rd_rsp_valid), .rd_rsp_data_i(rd_rsp_data),
        .data_o(data), .data_valid_o(data_valid), .data_ready_i(data_ready),
        .busy_o(busy), .done_o(done), .outst_full_o(outst_full)
`ifdef CGRA_STREAMER_PERF_CNT_EN
        , .stall_count_o(stall_count)
`endif
    );

    typedef struct {int due; logic [31:0] addr;} pend_t;

    int checks = 0, failures = 0;
    logic [31:0] obs_addr[$], obs_data[$];
    int first_req_cyc, done_cyc, done_cnt, busy_seen, stab_err, full_err, max_out, hold_reqs, timeout;
    logic hold_full, hold_valid, pre_dv;
    logic [4:0] snap_ctrl;
    logic [31:0] snap_addr, snap_data;

    // Memory contents as seen by the streamer: a fixed scramble of the address.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] b, input logic [15:0] st, input int n);
        logic [31:0] s, k;
        s = {16'h0, st};
        k = n;
        return b + s * k;
    endfunction

    // Runs one stream: launches execute, answers reads in order with random latency,
    // drives data_ready, and records what the DUT did.
    task automatic drive_stream(input logic [31:0] b, input logic [15:0] sz, input logic [15:0] st,
                                input int rdy_pct, input int lat_min, input int lat_max,
                                input int hold_low, input int stall_after, input int abort_cyc);
        pend_t pend[$];
        int cyc, last_due, n_req, n_del, stall_left, lat, due;
        bit prev_wait, seen_valid, rdy, drdy;
        logic [31:0] prev_addr;
        obs_addr.delete(); obs_data.delete();
        first_req_cyc = -1; done_cyc = -1; done_cnt = 0; busy_seen = 0; stab_err = 0; full_err = 0;
        max_out = 0; hold_reqs = -1; timeout = 0; hold_full = 0; hold_valid = 0; pre_dv = 0;
        cyc = 0; last_due = 0; n_req = 0; n_del = 0; stall_left = 0;
        prev_wait = 0; seen_valid = 0; prev_addr = '0;
        @(negedge clk);
        execute = 1'b1; base_addr = b; size = sz; stride = st;
        rd_req_ready = 1'b0; data_ready = 1'b0; rd_rsp_valid = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            execute = 1'b0;
            if (cyc == abort_cyc) begin
                pre_dv = data_valid;
                rst = 1'b1; rd_req_ready = 1'b0; data_ready = 1'b0; rd_rsp_valid = 1'b0;
                #1;
                snap_ctrl = {rd_req_valid, data_valid, done, busy, outst_full};
                snap_addr = rd_req_addr; snap_data = data;
                break;
            end
            if (cyc == hold_low) begin
                hold_reqs = n_req; hold_full = outst_full; hold_valid = rd_req_valid;
            end
            if (busy) busy_seen = 1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                rd_rsp_valid = 1'b1; rd_rsp_data = data_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                rd_rsp_valid = 1'b0; rd_rsp_data = $urandom;
            end
            if (prev_wait && !(rd_req_valid && rd_req_addr == prev_addr)) stab_err++;
            if (outst_full && rd_req_valid) full_err++;
            rdy = ($urandom_range(99) < rdy_pct);
            if (rd_req_valid && rdy) begin
                obs_addr.push_back(rd_req_addr);
                lat = $urandom_range(lat_max, lat_min);
                due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                pend.push_back('{due, rd_req_addr});
                last_due = due; n_req++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            prev_wait = rd_req_valid && !rdy; prev_addr = rd_req_addr;
            if (n_req - n_del > max_out) max_out = n_req - n_del;
            if (data_valid && !seen_valid) begin
                seen_valid = 1; stall_left = stall_after;
            end
            drdy = (cyc > hold_low) && ($urandom_range(99) < rdy_pct);
            if (stall_left > 0) begin
                drdy = 0; stall_left--;
            end
            if (data_valid && drdy) begin
                obs_data.push_back(data); n_del++;
            end
            rd_req_ready = rdy; data_ready = drdy;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc >= 3000) begin
                timeout = 1; break;
            end
        end
        rd_req_ready = 1'b0; data_ready = 1'b0; rd_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({rd_req_valid, data_valid, done, busy, outst_full} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {rd_req_valid, data_valid, done, busy, outst_full}); end
        checks++; if (rd_req_addr !== 32'h0 || data !== 32'h0) begin failures++; $display("FAIL reset_bus got addr=%h data=%h exp=0", rd_req_addr, data); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rd_req_valid !== 1'b0) begin failures++; $display("FAIL reset_idle got busy=%b valid=%b exp=0", busy, rd_req_valid); end
    endtask

    task automatic test_basic();
        drive_stream(32'h8000_0000, 16'd4, 16'd8, 100, 1, 1, 0, 0, -1);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL basic_timeout got=%0d exp=0", timeout); end
        checks++; if (first_req_cyc !== 1) begin failures++; $display("FAIL basic_first_req got=%0d exp=1", first_req_cyc); end
        checks++; if (obs_addr.size() !== 4) begin failures++; $display("FAIL basic_nreq got=%0d exp=4", obs_addr.size()); end
        for (int n = 0; n < 4 && n < obs_addr.size(); n++) begin
            checks++; if (obs_addr[n] !== 32'h8000_0000 + 32'(n * 8)) begin failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", n, obs_addr[n], 32'h8000_0000 + 32'(n * 8)); end
        end
        checks++; if (obs_data.size() !== 4) begin failures++; $display("FAIL basic_ndata got=%0d exp=4", obs_data.size()); end
        for (int n = 0; n < 4 && n < obs_data.size(); n++) begin
            checks++; if (obs_data[n] !== data_of(exp_addr(32'h8000_0000, 16'd8, n))) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", n, obs_data[n], data_of(exp_addr(32'h8000_0000, 16'd8, n))); end
        end
        checks++; if (done_cyc !== 7) begin failures++; $display("FAIL basic_done_cyc got=%0d exp=7", done_cyc); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_size_zero();
        drive_stream(32'h0000_1234, 16'd0, 16'd4, 100, 1, 1, 0, 0, -1);
        checks++; if (done_cyc !== 1) begin failures++; $display("FAIL zero_done_cyc got=%0d exp=1", done_cyc); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
        checks++; if (busy_seen !== 0) begin failures++; $display("FAIL zero_busy got=%0d exp=0", busy_seen); end
        checks++; if (obs_addr.size() !== 0) begin failures++; $display("FAIL zero_nreq got=%0d exp=0", obs_addr.size()); end
    endtask

    task automatic test_backpressure();
        drive_stream(32'h0000_1000, 16'd8, 16'd4, 100, 1, 1, 20, 0, -1);
        checks++; if (hold_reqs !== DEPTH) begin failures++; $display("FAIL bp_reqs got=%0d exp=%0d", hold_reqs, DEPTH); end
        checks++; if (hold_full !== 1'b1) begin failures++; $display("FAIL bp_full got=%b exp=1", hold_full); end
        checks++; if (hold_valid !== 1'b0) begin failures++; $display("FAIL bp_valid got=%b exp=0", hold_valid); end
        checks++; if (full_err !== 0) begin failures++; $display("FAIL bp_full_valid got=%0d exp=0", full_err); end
        checks++; if (timeout !== 0 || done_cnt !== 1) begin failures++; $display("FAIL bp_done got timeout=%0d done=%0d exp=0/1", timeout, done_cnt); end
        checks++; if (obs_data.size() !== 8) begin failures++; $display("FAIL bp_ndata got=%0d exp=8", obs_data.size()); end
        for (int n = 0; n < 8 && n < obs_data.size(); n++) begin
            checks++; if (obs_data[n] !== data_of(exp_addr(32'h0000_1000, 16'd4, n))) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", n, obs_data[n], data_of(exp_addr(32'h0000_1000, 16'd4, n))); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFF8; exp[1] = 32'h0000_0000; exp[2] = 32'h0000_0008;
        drive_stream(32'hFFFF_FFF8, 16'd3, 16'd8, 100, 1, 2, 0, 0, -1);
        checks++; if (obs_addr.size() !== 3) begin failures++; $display("FAIL wrap_nreq got=%0d exp=3", obs_addr.size()); end
        for (int n = 0; n < 3 && n < obs_addr.size(); n++) begin
            checks++; if (obs_addr[n] !== exp[n]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", n, obs_addr[n], exp[n]); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL wrap_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_midstream_reset();
        // Latency 3 and no pops: at cycle 5 two reads are outstanding and one word is buffered.
        drive_stream(32'h0000_4000, 16'd3, 16'd4, 100, 3, 3, 100, 0, 5);
        checks++; if (pre_dv !== 1'b1) begin failures++; $display("FAIL mrst_buffered got=%b exp=1", pre_dv); end
        checks++; if (snap_ctrl !== 5'b0) begin failures++; $display("FAIL mrst_ctrl got=%b exp=00000", snap_ctrl); end
        checks++; if (snap_addr !== 32'h0 || snap_data !== 32'h0) begin failures++; $display("FAIL mrst_bus got addr=%h data=%h exp=0", snap_addr, snap_data); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_stream(32'h0000_5000, 16'd5, 16'd12, 100, 1, 1, 0, 0, -1);
        checks++; if (obs_addr.size() !== 5 || obs_data.size() !== 5 || done_cnt !== 1) begin failures++; $display("FAIL mrst_fresh got nreq=%0d ndata=%0d done=%0d exp=5/5/1", obs_addr.size(), obs_data.size(), done_cnt); end
        for (int n = 0; n < 5 && n < obs_data.size(); n++) begin
            checks++; if (obs_data[n] !== data_of(exp_addr(32'h0000_5000, 16'd12, n))) begin failures++; $display("FAIL mrst_data[%0d] got=%h exp=%h", n, obs_data[n], data_of(exp_addr(32'h0000_5000, 16'd12, n))); end
        end
    endtask

    task automatic test_random();
        logic [31:0] b;
        logic [15:0] sz, st;
        for (int it = 0; it < 8; it++) begin
            b  = $urandom;
            sz = 16'($urandom_range(12, 1));
            st = (it % 2 == 0) ? 16'($urandom_range(65535, 0)) : 16'($urandom_range(16, 0));
            drive_stream(b, sz, st, $urandom_range(100, 40), 1, 4, 0, 0, -1);
            checks++; if (timeout !== 0 || done_cnt !== 1) begin failures++; $display("FAIL rnd%0d_done got timeout=%0d done=%0d exp=0/1", it, timeout, done_cnt); end
            checks++; if (obs_addr.size() !== int'(sz) || obs_data.size() !== int'(sz)) begin failures++; $display("FAIL rnd%0d_count got nreq=%0d ndata=%0d exp=%0d", it, obs_addr.size(), obs_data.size(), sz); end
            for (int n = 0; n < int'(sz) && n < obs_addr.size() && n < obs_data.size(); n++) begin
                checks++; if (obs_addr[n] !== exp_addr(b, st, n)) begin failures++; $display("FAIL rnd%0d_addr[%0d] got=%h exp=%h", it, n, obs_addr[n], exp_addr(b, st, n)); end
                checks++; if (obs_data[n] !== data_of(exp_addr(b, st, n))) begin failures++; $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", it, n, obs_data[n], data_of(exp_addr(b, st, n))); end
            end
            checks++; if (stab_err !== 0 || full_err !== 0) begin failures++; $display("FAIL rnd%0d_handshake got stab=%0d full=%0d exp=0/0", it, stab_err, full_err); end
            checks++; if (max_out > DEPTH) begin failures++; $display("FAIL rnd%0d_credit got=%0d exp<=%0d", it, max_out, DEPTH); end
        end
    endtask

`ifdef CGRA_STREAMER_PERF_CNT_EN
    task automatic test_perf_cnt();
        drive_stream(32'h0000_2000, 16'd1, 16'd4, 100, 1, 1, 0, 5, -1);
        checks++; if (stall_count !== 32'd5) begin failures++; $display("FAIL perf_stall got=%0d exp=5", stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_size_zero();
        test_backpressure();
        test_wrap();
        test_midstream_reset();
        test_random();
`ifdef CGRA_STREAMER_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
